// File: rtl/sync_fifo_write_arbiter.sv
// ============================================================================
// Module   : sync_fifo_write_arbiter
// Purpose  : Round-robin burst arbiter that shares one FIFO write port among
//            N_REQ valid/ready producers and tags each beat with its source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [N_REQ-1:0]                 req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_data_i,
  output logic [N_REQ-1:0]                 req_ready_o,
  input  logic                             fifo_full_i,
  output logic                             fifo_write_o,
  output logic [$clog2(N_REQ)+DATA_WIDTH-1:0] fifo_wr_data_o,
  output logic [$clog2(N_REQ)-1:0]         grant_id_o,
  output logic                             busy_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_owner;
  logic [ID_W-1:0]  r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_cand;
  logic             w_cand_vld;
  logic [ID_W-1:0]  w_sel;
  logic             w_write;
  logic             w_owner_valid;

  // Wrap-around scan starting just after the last released owner.
  always_comb begin
    w_idx      = '0;
    w_cand     = '0;
    w_cand_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % N_REQ);
      if (!w_cand_vld && req_valid_i[w_idx]) begin
        w_cand_vld = 1'b1;
        w_cand     = w_idx;
      end
    end
  end

  assign w_owner_valid = req_valid_i[r_owner];

  // Write is gated by reset so an asserted reset silences the port instantly.
  always_comb begin
    w_write = 1'b0;
    w_sel   = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_cand_vld && !fifo_full_i && rst_n_i) begin
          w_write = 1'b1;
          w_sel   = w_cand;
        end
      end
      S_BURST: begin
        if (w_owner_valid && !fifo_full_i && rst_n_i) begin
          w_write = 1'b1;
        end
      end
      default: begin
        w_write = 1'b0;
      end
    endcase
  end

  assign fifo_write_o   = w_write;
  assign req_ready_o    = w_write ? (N_REQ'(1) << w_sel) : '0;
  assign fifo_wr_data_o = {w_sel, req_data_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH]};
  assign grant_id_o     = r_owner;
  assign busy_o         = r_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= ID_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_write) begin
            r_owner <= w_cand;
            r_cnt   <= CNT_W'(1);
            if (MAX_BURST == 1) begin
              r_last <= w_cand;
            end else begin
              r_state <= S_BURST;
              r_busy  <= 1'b1;
            end
          end
        end
        S_BURST: begin
          // A dropped valid releases with a one-cycle bubble; full only stalls.
          if (!w_owner_valid) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!fifo_full_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(MAX_BURST - 1)) begin
              r_last  <= r_owner;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_write_arbiter.sv
// ============================================================================
// Module   : tb_sync_fifo_write_arbiter
// Purpose  : Table-driven and directed self-checking bench for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_write;
  logic [DW+1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  logic full_drv;
  logic mdl_en;
  logic mdl_rd;
  int   mdl_pre;
  int   mdl_cnt;

  int n_vec;
  int n_err;
  int beats [N];

  sync_fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .fifo_full_i    (fifo_full),
    .fifo_write_o   (fifo_write),
    .fifo_wr_data_o (fifo_wr_data),
    .grant_id_o     (grant_id),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-8 FIFO occupancy model used by the stall sequence.
  always @(posedge clk) begin
    if (!mdl_en) mdl_cnt <= mdl_pre;
    else mdl_cnt <= mdl_cnt + (fifo_write ? 1 : 0) - (mdl_rd ? 1 : 0);
  end
  assign fifo_full = mdl_en ? (mdl_cnt == 8) : full_drv;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic       exp_wr;
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    logic       exp_busy;
    logic [1:0] exp_tag;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] mkdat(input int p, input int b);
    return 32'hA500_0000 | (32'(p) << 16) | 32'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Commits the beat consumed in the cycle just checked, then drives the next one.
  task automatic drive(input logic [3:0] v, input logic rd);
    if (fifo_write)
      for (int p = 0; p < N; p++) if (req_ready[p]) beats[p]++;
    @(negedge clk);
    req_valid = v;
    mdl_rd    = rd;
    for (int p = 0; p < N; p++) req_data[p*DW +: DW] = mkdat(p, beats[p]);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    full_drv  = 1'b0;
    mdl_en    = 1'b0;
    mdl_rd    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) beats[p] = 0;
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [3:0] r,
                         input logic [1:0] id, input logic b);
    chk({tag, "_write"}, 64'(fifo_write), 64'(w));
    chk({tag, "_ready"}, 64'(req_ready), 64'(r));
    chk({tag, "_id"},    64'(grant_id), 64'(id));
    chk({tag, "_busy"},  64'(busy), 64'(b));
  endtask

  initial begin
    int k;
    int n;
    int total;
    int mh_bad;
    int eo;
    int wcyc [6];

    n_vec = 0; n_err = 0;
    mdl_pre = 0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; full_drv = 1'b0;
    mdl_en = 1'b0; mdl_rd = 1'b0;
    for (int p = 0; p < N; p++) beats[p] = 0;

    //                 valid    full  wr    rdy      id     busy  tag
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd0, 1'b0, 2'd2};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};
    tbl[3]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 2'd0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};
    tbl[5]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};
    tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 2'd2, 1'b0, 2'd3};
    tbl[7]  = '{4'b0111, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd0};
    tbl[8]  = '{4'b0111, 1'b0, 1'b1, 4'b0001, 2'd3, 1'b0, 2'd0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 2'd0};
    tbl[10] = '{4'b1001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0};
    tbl[11] = '{4'b1001, 1'b0, 1'b1, 4'b1000, 2'd0, 1'b0, 2'd3};
    tbl[12] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd0};
    tbl[14] = '{4'b1001, 1'b0, 1'b1, 4'b0001, 2'd3, 1'b0, 2'd0};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 2'd0};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0};

    // Reset: outputs quiet even with every producer valid.
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk_out("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors from a fresh reset.
    for (int p = 0; p < N; p++) req_data[p*DW +: DW] = mkdat(p, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid;
      full_drv  = tbl[i].full;
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].exp_wr, tbl[i].exp_rdy,
              tbl[i].exp_id, tbl[i].exp_busy);
      if (tbl[i].exp_wr)
        chk($sformatf("vec%0d_data", i), 64'(fifo_wr_data),
            64'({tbl[i].exp_tag, mkdat(int'(tbl[i].exp_tag), 0)}));
    end

    // Single producer 2, six beats.
    do_reset();
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      drive(4'b0100, 1'b0);
      if (fifo_write) begin
        chk("single_data", 64'(fifo_wr_data), 64'({2'd2, mkdat(2, k)}));
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        wcyc[k] = c;
        k++;
      end
    end
    chk("single_count", 64'(k), 64'(6));
    chk("single_first_burst_consecutive", 64'(wcyc[3] - wcyc[0]), 64'(3));
    drive(4'b0000, 1'b0);

    // Rotation: all four valid, 16 beats each.
    do_reset();
    total = 0; mh_bad = 0;
    for (int c = 0; c < 200 && total < 64; c++) begin
      drive({beats[3] < 16, beats[2] < 16, beats[1] < 16, beats[0] < 16}, 1'b0);
      if ($countones(req_ready) > 1) mh_bad++;
      if (fifo_write) begin
        eo = (total / 4) % 4;
        chk("rot_data", 64'(fifo_wr_data), 64'({2'(eo), mkdat(eo, beats[eo])}));
        total++;
      end
    end
    chk("rot_total", 64'(total), 64'(64));
    chk("rot_onehot", 64'(mh_bad), 64'(0));
    drive(4'b0000, 1'b0);

    // Full stall with a depth-8 FIFO preloaded with 2 entries.
    mdl_pre = 2;
    do_reset();
    mdl_en = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      drive(4'b0011, 1'b0);
      if (fifo_write) begin
        eo = (n < 4) ? 0 : 1;
        chk("stall_fill_data", 64'(fifo_wr_data),
            64'({2'(eo), mkdat(eo, (n < 4) ? n : n - 4)}));
        n++;
      end
    end
    chk("stall_fill_count", 64'(n), 64'(6));
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011, 1'b0);
      chk_out("stall_hold", 1'b0, 4'b0000, 2'd1, 1'b1);
    end
    drive(4'b0011, 1'b1);
    chk_out("stall_read1", 1'b0, 4'b0000, 2'd1, 1'b1);
    drive(4'b0011, 1'b1);
    chk_out("stall_resume3", 1'b1, 4'b0010, 2'd1, 1'b1);
    chk("stall_resume3_data", 64'(fifo_wr_data), 64'({2'd1, mkdat(1, 2)}));
    drive(4'b0011, 1'b0);
    chk_out("stall_resume4", 1'b1, 4'b0010, 2'd1, 1'b1);
    chk("stall_resume4_data", 64'(fifo_wr_data), 64'({2'd1, mkdat(1, 3)}));
    drive(4'b0011, 1'b0);
    chk_out("stall_idle_full", 1'b0, 4'b0000, 2'd1, 1'b0);
    drive(4'b0011, 1'b1);
    chk("stall_idle_read_nowrite", 64'(fifo_write), 64'(0));
    drive(4'b0011, 1'b0);
    chk_out("stall_next_owner", 1'b1, 4'b0001, 2'd1, 1'b0);
    chk("stall_next_data", 64'(fifo_wr_data), 64'({2'd0, mkdat(0, 4)}));
    drive(4'b0000, 1'b0);
    mdl_en = 1'b0;
    mdl_pre = 0;

    // Valid drop: producer 1 drops after 2 beats, producer 3 waiting.
    do_reset();
    drive(4'b1010, 1'b0);
    chk_out("drop_b1", 1'b1, 4'b0010, 2'd0, 1'b0);
    drive(4'b1010, 1'b0);
    chk_out("drop_b2", 1'b1, 4'b0010, 2'd1, 1'b1);
    drive(4'b1000, 1'b0);
    chk_out("drop_release", 1'b0, 4'b0000, 2'd1, 1'b1);
    drive(4'b1000, 1'b0);
    chk_out("drop_p3", 1'b1, 4'b1000, 2'd1, 1'b0);
    chk("drop_p3_data", 64'(fifo_wr_data), 64'({2'd3, mkdat(3, 0)}));
    drive(4'b0000, 1'b0);

    // Asynchronous reset in the middle of beat 2 of a burst.
    do_reset();
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    chk_out("areset_pre", 1'b1, 4'b0100, 2'd2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("areset_now", 1'b0, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) beats[p] = 0;
    drive(4'b1010, 1'b0);
    chk_out("areset_after", 1'b1, 4'b0010, 2'd0, 1'b0);
    drive(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
